// File: rtl/cpu_mem_pkg.sv
// Shared widths, defaults and FSM state encodings for the CPU memory controller.
package cpu_mem_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int MAR_W   = 16;
    localparam int RD_WAIT = 1;

    // Data channel: loads use D_WAIT, stores walk PRIME then COMMIT.
    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_WAIT   = 2'd1,
        D_PRIME  = 2'd2,
        D_COMMIT = 2'd3
    } data_state_t;

    // Fetch channel: a single wait state covers the read latency.
    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_t;

    // Width of a down-counter holding values 0 .. n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_mem_fetch_port.sv
// Instruction-fetch channel: drives the memory MAR read port and returns the word
// after RD_WAIT edges. The stall input comes from the address-hazard compare in the top.
module cpu_mem_fetch_port #(
    parameter int ADDR_W  = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W  = cpu_mem_pkg::DATA_W,
    parameter int MAR_W   = cpu_mem_pkg::MAR_W,
    parameter int RD_WAIT = cpu_mem_pkg::RD_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    input  logic [DATA_W-1:0] mem_data,
    output logic [MAR_W-1:0]  mar,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              in_flight,
    output logic [ADDR_W-1:0] flight_addr
);
    import cpu_mem_pkg::*;

    localparam int CNT_W = cnt_width(RD_WAIT);

    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept      = req & (state == F_IDLE) & ~stall;
    assign busy        = (state != F_IDLE) | stall;
    assign in_flight   = (state == F_WAIT);
    assign flight_addr = mar[ADDR_W-1:0];

    // Fetch FSM: capture the address on accept, count down the read latency, then sample the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= F_IDLE;
            cnt   <= '0;
            mar   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (accept) begin
                        mar   <= MAR_W'(addr);
                        cnt   <= CNT_W'(RD_WAIT - 1);
                        state <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (cnt == '0) begin
                        data  <= mem_data;
                        valid <= 1'b1;
                        state <= F_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_memory_ctrl.sv
// Initiator side of the CPU memory interface: fetch and load/store channels running
// concurrently against a 256x16 array, with an address hazard check between fetch and store.
module cpu_memory_ctrl #(
    parameter int ADDR_W  = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W  = cpu_mem_pkg::DATA_W,
    parameter int MAR_W   = cpu_mem_pkg::MAR_W,
    parameter int RD_WAIT = cpu_mem_pkg::RD_WAIT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_BUSY,
    output logic              IF_VALID,
    output logic [DATA_W-1:0] IF_DATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_BUSY,
    output logic              D_DONE,
    output logic [DATA_W-1:0] D_RDATA,
    output logic [MAR_W-1:0]  MAR,
    input  logic [DATA_W-1:0] OUT_MEMORY,
    output logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] OUT_ADDRESS_MEMORY,
    output logic [DATA_W-1:0] IN_ADDRESS_MEMORY
);
    import cpu_mem_pkg::*;

    localparam int CNT_W = cnt_width(RD_WAIT);

    data_state_t      d_state;
    logic [CNT_W-1:0] d_cnt;
    logic [DATA_W-1:0] wdata_q;

    // The memory writes whenever its write data changes, so these two registers are
    // deliberately left out of reset: a reset must never produce a write event.
    logic [ADDR_W-1:0] address_q  = '0;
    logic [DATA_W-1:0] wr_data_q  = '0;

    logic              fetch_in_flight;
    logic [ADDR_W-1:0] fetch_addr;
    logic              store_in_flight;
    logic              store_stall;
    logic              fetch_stall;
    logic              d_accept;
    logic              store_accept;

    assign ADDRESS           = address_q;
    assign IN_ADDRESS_MEMORY = wr_data_q;

    // A store must not overtake an in-flight fetch of the same word; loads never conflict.
    assign store_stall     = D_REQ & D_WE & fetch_in_flight & (fetch_addr == D_ADDR);
    assign d_accept        = ~RST & D_REQ & (d_state == D_IDLE) & ~store_stall;
    assign store_accept    = d_accept & D_WE;
    assign store_in_flight = (d_state == D_PRIME) | (d_state == D_COMMIT);

    // A fetch waits behind an in-flight store to its address, and loses a same-edge tie to a store.
    assign fetch_stall = IF_REQ &
                         ((store_in_flight & (address_q == IF_ADDR)) |
                          (store_accept & (D_ADDR == IF_ADDR)));

    assign D_BUSY = (d_state != D_IDLE) | store_stall;

    cpu_mem_fetch_port #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAR_W   (MAR_W),
        .RD_WAIT (RD_WAIT)
    ) u_fetch (
        .clk         (CLK),
        .rst         (RST),
        .req         (IF_REQ),
        .addr        (IF_ADDR),
        .stall       (fetch_stall),
        .mem_data    (OUT_MEMORY),
        .mar         (MAR),
        .data        (IF_DATA),
        .valid       (IF_VALID),
        .busy        (IF_BUSY),
        .in_flight   (fetch_in_flight),
        .flight_addr (fetch_addr)
    );

    // Data FSM: loads wait out the read latency; stores prime then commit, pulsing D_DONE on commit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            d_state <= D_IDLE;
            d_cnt   <= '0;
            wdata_q <= '0;
            D_RDATA <= '0;
            D_DONE  <= 1'b0;
        end else begin
            D_DONE <= 1'b0;
            case (d_state)
                D_IDLE: begin
                    if (d_accept) begin
                        wdata_q <= D_WDATA;
                        if (D_WE) begin
                            d_state <= D_PRIME;
                        end else begin
                            d_cnt   <= CNT_W'(RD_WAIT - 1);
                            d_state <= D_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (d_cnt == '0) begin
                        D_RDATA <= OUT_ADDRESS_MEMORY;
                        D_DONE  <= 1'b1;
                        d_state <= D_IDLE;
                    end else begin
                        d_cnt <= d_cnt - 1'b1;
                    end
                end
                D_PRIME: begin
                    d_state <= D_COMMIT;
                end
                D_COMMIT: begin
                    D_DONE  <= 1'b1;
                    d_state <= D_IDLE;
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    // Memory port drive: address on accept, then the inverted word to force a change event, then the word.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (d_accept) begin
                address_q <= D_ADDR;
            end
            if (d_state == D_PRIME) begin
                wr_data_q <= ~wdata_q;
            end else if (d_state == D_COMMIT) begin
                wr_data_q <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_cpu_memory_ctrl.sv
// Directed self-checking bench for cpu_memory_ctrl with a behavioural 256x16 memory.
module tb_cpu_memory_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ;
    logic [7:0]  IF_ADDR;
    logic        IF_BUSY;
    logic        IF_VALID;
    logic [15:0] IF_DATA;
    logic        D_REQ;
    logic        D_WE;
    logic [7:0]  D_ADDR;
    logic [15:0] D_WDATA;
    logic        D_BUSY;
    logic        D_DONE;
    logic [15:0] D_RDATA;
    logic [15:0] MAR;
    logic [15:0] OUT_MEMORY;
    logic [7:0]  ADDRESS;
    logic [15:0] OUT_ADDRESS_MEMORY;
    logic [15:0] IN_ADDRESS_MEMORY;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    cpu_memory_ctrl dut (
        .CLK                (CLK),
        .RST                (RST),
        .IF_REQ             (IF_REQ),
        .IF_ADDR            (IF_ADDR),
        .IF_BUSY            (IF_BUSY),
        .IF_VALID           (IF_VALID),
        .IF_DATA            (IF_DATA),
        .D_REQ              (D_REQ),
        .D_WE               (D_WE),
        .D_ADDR             (D_ADDR),
        .D_WDATA            (D_WDATA),
        .D_BUSY             (D_BUSY),
        .D_DONE             (D_DONE),
        .D_RDATA            (D_RDATA),
        .MAR                (MAR),
        .OUT_MEMORY         (OUT_MEMORY),
        .ADDRESS            (ADDRESS),
        .OUT_ADDRESS_MEMORY (OUT_ADDRESS_MEMORY),
        .IN_ADDRESS_MEMORY  (IN_ADDRESS_MEMORY)
    );

    always #5 CLK = ~CLK;

    // Memory model: combinational reads, write to mem[ADDRESS] on every change of write data.
    assign OUT_MEMORY         = mem[MAR[7:0]];
    assign OUT_ADDRESS_MEMORY = mem[ADDRESS];

    always @(IN_ADDRESS_MEMORY) mem[ADDRESS] = IN_ADDRESS_MEMORY;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Accept edge E0, drop requests, then record the first edge index at which each pulse is seen.
    task automatic run_until_done(input int max_edges, output int if_edge, output int d_edge);
        if_edge = -1;
        d_edge  = -1;
        tick();
        IF_REQ = 1'b0;
        D_REQ  = 1'b0;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (IF_VALID === 1'b1 && if_edge < 0) if_edge = i;
            if (D_DONE === 1'b1 && d_edge < 0) d_edge = i;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; IF_REQ = 1'b0; IF_ADDR = 8'd0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 8'd0; D_WDATA = 16'd0;
        tick();
        tick();
        checks++;
        if ({MAR, IF_DATA, D_RDATA} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: MAR=%h IF_DATA=%h D_RDATA=%h expected all 0", MAR, IF_DATA, D_RDATA);
        end
        checks++;
        if ({IF_VALID, D_DONE, IF_BUSY, D_BUSY} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected 0000", {IF_VALID, D_DONE, IF_BUSY, D_BUSY});
        end
        checks++;
        if (ADDRESS !== 8'd0 || IN_ADDRESS_MEMORY !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_port: ADDRESS=%h IN=%h expected 0/0", ADDRESS, IN_ADDRESS_MEMORY);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int ie, de;
        IF_REQ = 1'b1; IF_ADDR = 8'd100;
        run_until_done(4, ie, de);
        checks++;
        if (ie !== 1 || IF_DATA !== 16'h1001) begin
            errors++;
            $display("[TB] FAIL fetch_100: edge=%0d data=%h expected edge 1 data 1001", ie, IF_DATA);
        end
        checks++;
        if (MAR !== 16'd100) begin
            errors++;
            $display("[TB] FAIL fetch_mar: got %h expected 0064", MAR);
        end
    endtask

    task automatic test_load();
        int ie, de;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 8'd7; D_WDATA = 16'hFFFF;
        run_until_done(4, ie, de);
        checks++;
        if (de !== 1 || D_RDATA !== 16'h012C) begin
            errors++;
            $display("[TB] FAIL load_7: edge=%0d data=%h expected edge 1 data 012C", de, D_RDATA);
        end
        checks++;
        if (mem[7] !== 16'h012C || IN_ADDRESS_MEMORY !== 16'd0) begin
            errors++;
            $display("[TB] FAIL load_nowrite: mem7=%h IN=%h expected 012C/0000", mem[7], IN_ADDRESS_MEMORY);
        end
    endtask

    task automatic test_store();
        int ie, de;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'd10; D_WDATA = 16'h0132;
        run_until_done(4, ie, de);
        checks++;
        if (de !== 2 || mem[10] !== 16'h0132) begin
            errors++;
            $display("[TB] FAIL store_10: edge=%0d mem=%h expected edge 2 mem 0132", de, mem[10]);
        end
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'd11; D_WDATA = 16'h0132;
        run_until_done(4, ie, de);
        checks++;
        if (de !== 2 || mem[11] !== 16'h0132) begin
            errors++;
            $display("[TB] FAIL store_11_same_data: edge=%0d mem=%h expected edge 2 mem 0132", de, mem[11]);
        end
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 8'd11;
        run_until_done(4, ie, de);
        checks++;
        if (de !== 1 || D_RDATA !== 16'h0132) begin
            errors++;
            $display("[TB] FAIL load_11: edge=%0d data=%h expected edge 1 data 0132", de, D_RDATA);
        end
    endtask

    task automatic test_concurrent();
        int ie, de;
        IF_REQ = 1'b1; IF_ADDR = 8'd101;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 8'd2;
        run_until_done(4, ie, de);
        checks++;
        if (ie !== 1 || IF_DATA !== 16'h1102) begin
            errors++;
            $display("[TB] FAIL concurrent_fetch: edge=%0d data=%h expected edge 1 data 1102", ie, IF_DATA);
        end
        checks++;
        if (de !== 1 || D_RDATA !== 16'h0004) begin
            errors++;
            $display("[TB] FAIL concurrent_load: edge=%0d data=%h expected edge 1 data 0004", de, D_RDATA);
        end
    endtask

    task automatic test_same_edge_hazard();
        int  busy_cycles = 0;
        bit  done_seen = 0;
        bit  early_valid = 0;
        IF_REQ = 1'b1; IF_ADDR = 8'd5;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'd5; D_WDATA = 16'h0009;
        #1;
        checks++;
        if (IF_BUSY !== 1'b1 || D_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tie_busy: IF_BUSY=%b D_BUSY=%b expected 1/0", IF_BUSY, D_BUSY);
        end
        tick();
        D_REQ = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (D_DONE === 1'b1) begin
                done_seen = 1;
                break;
            end
            if (IF_BUSY === 1'b1) busy_cycles++;
            if (IF_VALID === 1'b1) early_valid = 1;
            tick();
        end
        checks++;
        if (!done_seen || busy_cycles != 2 || early_valid || IF_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tie_stall: done=%0d busy_cycles=%0d early=%0d busy_at_done=%b expected 1/2/0/0",
                     done_seen, busy_cycles, early_valid, IF_BUSY);
        end
        tick();
        IF_REQ = 1'b0;
        tick();
        checks++;
        if (IF_VALID !== 1'b1 || IF_DATA !== 16'h0009) begin
            errors++;
            $display("[TB] FAIL tie_fetch_data: valid=%b data=%h expected 1/0009", IF_VALID, IF_DATA);
        end
    endtask

    task automatic test_store_waits_fetch();
        int de = -1;
        IF_REQ = 1'b1; IF_ADDR = 8'd30;
        tick();
        IF_REQ = 1'b0;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'd30; D_WDATA = 16'h0077;
        #1;
        checks++;
        if (D_BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_stall_busy: got %b expected 1", D_BUSY);
        end
        tick();
        checks++;
        if (IF_VALID !== 1'b1 || IF_DATA !== 16'h3030 || D_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_stall_release: valid=%b data=%h D_BUSY=%b expected 1/3030/0",
                     IF_VALID, IF_DATA, D_BUSY);
        end
        tick();
        D_REQ = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (D_DONE === 1'b1 && de < 0) de = i;
        end
        checks++;
        if (de !== 2 || mem[30] !== 16'h0077) begin
            errors++;
            $display("[TB] FAIL store_after_fetch: edge=%0d mem=%h expected edge 2 mem 0077", de, mem[30]);
        end
    endtask

    task automatic test_reset_mid_store();
        int ie, de;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'd20; D_WDATA = 16'h00AA;
        tick();
        D_REQ = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        checks++;
        if ({IF_VALID, D_DONE, IF_BUSY, D_BUSY} !== 4'b0000 || D_RDATA !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_status: status=%b D_RDATA=%h expected 0000/0000",
                     {IF_VALID, D_DONE, IF_BUSY, D_BUSY}, D_RDATA);
        end
        checks++;
        if (mem[20] !== 16'hFF55) begin
            errors++;
            $display("[TB] FAIL midreset_mem: got %h expected FF55", mem[20]);
        end
        RST = 1'b0;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 8'd7;
        run_until_done(4, ie, de);
        checks++;
        if (de !== 1 || D_RDATA !== 16'h012C) begin
            errors++;
            $display("[TB] FAIL midreset_reload: edge=%0d data=%h expected edge 1 data 012C", de, D_RDATA);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[100] = 16'h1001;
        mem[101] = 16'h1102;
        mem[7]   = 16'h012C;
        mem[2]   = 16'h0004;
        mem[10]  = 16'h0AAA;
        mem[11]  = 16'h0BBB;
        mem[5]   = 16'h0055;
        mem[20]  = 16'h1234;
        mem[30]  = 16'h3030;
        $display("[TB] starting cpu_memory_ctrl directed tests");
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_concurrent();
        test_same_edge_hazard();
        test_store_waits_fetch();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
